leaf_packet_tx: RTL and testbench

- Transmit-side packetizer for a leaf. Converts a user-kernel 32-bit vld/ack output stream into 49-bit BFT packets addressed to one configured destination leaf/port.
- Enforces credit-based flow control toward the receiving leaf's input BRAM. Credits are replenished by freespace-update packets arriving from the BFT.
- Sits between a user kernel output port and the BFT, on the 400 MHz network clock domain.

---
 rtl/leaf_packet_tx_if.sv | 22 ++
 rtl/leaf_packet_tx.sv | 103 ++++++++++
 tb/tb_leaf_packet_tx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/leaf_packet_tx_if.sv
// rtl/leaf_packet_tx_if.sv - user-kernel stream and BFT link bundle for leaf_packet_tx
interface leaf_packet_tx_if #(
  parameter int PACKET_BITS  = 49,
  parameter int PAYLOAD_BITS = 32
);
  logic [PAYLOAD_BITS-1:0] din_leaf_user2tx;
  logic                    vld_user2tx;
  logic                    ack_tx2user;
  logic [PACKET_BITS-1:0]  din_leaf_bft2tx;
  logic [PACKET_BITS-1:0]  dout_tx2bft;
  logic                    resend;

  modport master (
    output din_leaf_user2tx, vld_user2tx, din_leaf_bft2tx, resend,
    input  ack_tx2user, dout_tx2bft
  );

  modport slave (
    input  din_leaf_user2tx, vld_user2tx, din_leaf_bft2tx, resend,
    output ack_tx2user, dout_tx2bft
  );
endinterface

// File: rtl/leaf_packet_tx.sv
// rtl/leaf_packet_tx.sv - credit-controlled packetizer from user stream to BFT packets
module leaf_packet_tx #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int INIT_CREDITS          = 128,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ap_start,
  input  logic [NUM_LEAF_BITS-1:0] self_leaf,
  input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] dest_port,
  leaf_packet_tx_if.slave          link,
  output logic [7:0]               credit_count,
  output logic                     err_credit_ovf
);

  localparam int PORT_LSB = PAYLOAD_BITS + NUM_ADDR_BITS;
  localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t                   state, state_next;
  logic [NUM_ADDR_BITS-1:0] seq;
  logic                     ack;
  logic                     xfer;
  logic                     upd;
  logic [9:0]               credit_sum;
  logic                     credit_ovf;
  logic [7:0]               credit_next;
  logic                     unused_bft;

  // Only the header of incoming packets matters; payload bits are don't-care.
  assign unused_bft = ^link.din_leaf_bft2tx[PORT_LSB-1:0];

  assign upd = link.din_leaf_bft2tx[PACKET_BITS-1]
            && (link.din_leaf_bft2tx[LEAF_LSB +: NUM_LEAF_BITS] == self_leaf)
            && (link.din_leaf_bft2tx[PORT_LSB +: NUM_PORT_BITS] == '0);

  assign xfer = link.vld_user2tx && ack;

  assign credit_sum = {2'b00, credit_count}
                    + (upd ? 10'(FREESPACE_UPDATE_SIZE) : 10'd0)
                    - {9'd0, xfer};
  assign credit_ovf  = credit_sum > 10'(INIT_CREDITS);
  assign credit_next = credit_ovf ? 8'(INIT_CREDITS) : credit_sum[7:0];

  assign link.ack_tx2user = ack;

  always_comb begin
    state_next = state;
    ack        = 1'b0;
    case (state)
      IDLE: begin
        if (ap_start) state_next = RUN;
      end
      RUN: begin
        ack = (credit_count != 8'd0) && !link.resend;
        if (credit_next == 8'd0 || link.resend) state_next = STALL;
      end
      STALL: begin
        if (credit_next != 8'd0 && !link.resend) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The output register is cleared on every non-transfer cycle so a packet is never repeated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      link.dout_tx2bft <= '0;
      seq              <= '0;
      credit_count     <= 8'(INIT_CREDITS);
      err_credit_ovf   <= 1'b0;
    end else begin
      credit_count <= credit_next;
      if (credit_ovf) err_credit_ovf <= 1'b1;
      if (xfer) begin
        link.dout_tx2bft <= {1'b1, dest_leaf, dest_port, seq, link.din_leaf_user2tx};
        seq              <= seq + 1'b1;
      end else begin
        link.dout_tx2bft <= '0;
      end
    end
  end

endmodule

// File: tb/tb_leaf_packet_tx.sv
// tb/tb_leaf_packet_tx.sv - self-checking bench for leaf_packet_tx
module tb_leaf_packet_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ap_start = 1'b0;
  logic [4:0] self_leaf = 5'd7;
  logic [4:0] dest_leaf = 5'd3;
  logic [3:0] dest_port = 4'd2;
  logic [7:0] credit_count;
  logic       err_credit_ovf;

  leaf_packet_tx_if lnk ();

  leaf_packet_tx dut (
    .clk           (clk),
    .reset         (reset),
    .ap_start      (ap_start),
    .self_leaf     (self_leaf),
    .dest_leaf     (dest_leaf),
    .dest_port     (dest_port),
    .link          (lnk),
    .credit_count  (credit_count),
    .err_credit_ovf(err_credit_ovf)
  );

  always #5 clk = ~clk;

  localparam logic [48:0] UPD = {1'b1, 5'd7, 4'd0, 7'd0, 32'h0};

  typedef struct {
    logic [48:0] pkt;
    logic [7:0]  exp_credit;
    logic        exp_err;
    logic        exp_ack;
  } upd_rec_t;

  upd_rec_t tbl[7];

  int errors = 0;
  int checks = 0;

  // Reference: credits/sequence as plain integers; "started" = left idle,
  // "go" = transfers permitted after the last edge.
  int m_credits = 128;
  int m_seq = 0;
  bit m_err = 1'b0;
  bit m_started = 1'b0;
  bit m_go = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ack(input logic rs);
    return m_started && m_go && (m_credits != 0) && !rs;
  endfunction

  // Starts and ends 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [31:0] d, input logic rs, input logic [48:0] bft);
    logic        xfer;
    logic        upd;
    logic [48:0] exp_dout;
    int          c;
    lnk.vld_user2tx      = v;
    lnk.din_leaf_user2tx = d;
    lnk.resend           = rs;
    lnk.din_leaf_bft2tx  = bft;
    @(negedge clk);
    chk("ack", {63'd0, lnk.ack_tx2user}, {63'd0, model_ack(rs)});
    xfer     = v && model_ack(rs);
    upd      = bft[48] && (bft[47:43] == self_leaf) && (bft[42:39] == 4'd0);
    exp_dout = xfer ? {1'b1, dest_leaf, dest_port, 7'(m_seq), d} : 49'd0;
    c = m_credits - (xfer ? 1 : 0) + (upd ? 64 : 0);
    if (c > 128) begin
      c = 128;
      m_err = 1'b1;
    end
    if (!m_started) begin
      if (ap_start) begin
        m_started = 1'b1;
        m_go = 1'b1;
      end
    end else begin
      m_go = !rs && (c > 0);
    end
    m_credits = c;
    if (xfer) m_seq = (m_seq + 1) % 128;
    @(posedge clk);
    #1;
    chk("dout", {15'd0, lnk.dout_tx2bft}, {15'd0, exp_dout});
    chk("credit", {56'd0, credit_count}, 64'(m_credits));
    chk("err", {63'd0, err_credit_ovf}, {63'd0, m_err});
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk("rst_ack", {63'd0, lnk.ack_tx2user}, 64'd0);
    chk("rst_dout", {15'd0, lnk.dout_tx2bft}, 64'd0);
    chk("rst_credit", {56'd0, credit_count}, 64'd128);
    chk("rst_err", {63'd0, err_credit_ovf}, 64'd0);
    m_credits = 128;
    m_seq = 0;
    m_err = 1'b0;
    m_started = 1'b0;
    m_go = 1'b0;
    ap_start = 1'b0;
    lnk.vld_user2tx = 1'b0;
    lnk.resend = 1'b0;
    lnk.din_leaf_bft2tx = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int accepted;
    logic [48:0] rnd_pkt;

    tbl[0] = '{{1'b0, 5'd7, 4'd0, 7'd0, 32'h0},        8'd0,   1'b0, 1'b0};
    tbl[1] = '{{1'b1, 5'd6, 4'd0, 7'd0, 32'h0},        8'd0,   1'b0, 1'b0};
    tbl[2] = '{{1'b1, 5'd7, 4'd1, 7'd0, 32'h0},        8'd0,   1'b0, 1'b0};
    tbl[3] = '{{1'b1, 5'd7, 4'd0, 7'd5, 32'hA5A5A5A5}, 8'd64,  1'b0, 1'b1};
    tbl[4] = '{{1'b1, 5'd7, 4'd0, 7'd0, 32'h0},        8'd128, 1'b0, 1'b1};
    tbl[5] = '{{1'b1, 5'd7, 4'd0, 7'd0, 32'h1},        8'd128, 1'b1, 1'b1};
    tbl[6] = '{{1'b1, 5'd3, 4'd2, 7'd9, 32'h2},        8'd128, 1'b1, 1'b1};

    lnk.vld_user2tx = 1'b0;
    lnk.din_leaf_user2tx = '0;
    lnk.resend = 1'b0;
    lnk.din_leaf_bft2tx = '0;

    // Power-on reset.
    #1 reset = 1'b0;
    #1;
    chk("por_ack", {63'd0, lnk.ack_tx2user}, 64'd0);
    chk("por_dout", {15'd0, lnk.dout_tx2bft}, 64'd0);
    chk("por_credit", {56'd0, credit_count}, 64'd128);
    chk("por_err", {63'd0, err_credit_ovf}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, '0);

    // Single word.
    ap_start = 1'b1;
    step(1'b0, 32'h0, 1'b0, '0);
    step(1'b1, 32'hDEADBEEF, 1'b0, '0);
    chk("first_pkt", {15'd0, lnk.dout_tx2bft}, {15'd0, 1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF});
    chk("first_credit", {56'd0, credit_count}, 64'd127);
    step(1'b0, 32'h0, 1'b0, '0);

    // Drain all credits with a continuous stream.
    do_reset();
    ap_start = 1'b1;
    step(1'b0, 32'h0, 1'b0, '0);
    accepted = 0;
    for (int i = 0; i < 130; i++) begin
      step(1'b1, $urandom, 1'b0, '0);
      if (lnk.dout_tx2bft[48]) accepted++;
    end
    chk("accepted", 64'(accepted), 64'd128);
    chk("drained_credit", {56'd0, credit_count}, 64'd0);
    chk("drained_ack", {63'd0, lnk.ack_tx2user}, 64'd0);

    // Freespace-update match table, starting from zero credits.
    lnk.vld_user2tx = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 32'h0, 1'b0, tbl[i].pkt);
      chk($sformatf("tbl%0d_credit", i), {56'd0, credit_count}, {56'd0, tbl[i].exp_credit});
      chk($sformatf("tbl%0d_err", i), {63'd0, err_credit_ovf}, {63'd0, tbl[i].exp_err});
      chk($sformatf("tbl%0d_ack", i), {63'd0, lnk.ack_tx2user}, {63'd0, tbl[i].exp_ack});
    end
    step(1'b1, 32'h12345678, 1'b0, '0);
    chk("seq_wrap", {57'd0, lnk.dout_tx2bft[38:32]}, 64'd0);

    // Overflow at 100, then simultaneous update+transfer at 10.
    do_reset();
    ap_start = 1'b1;
    step(1'b0, 32'h0, 1'b0, '0);
    for (int i = 0; i < 28; i++) step(1'b1, $urandom, 1'b0, '0);
    chk("credit_100", {56'd0, credit_count}, 64'd100);
    step(1'b0, 32'h0, 1'b0, UPD);
    chk("ovf_credit", {56'd0, credit_count}, 64'd128);
    chk("ovf_err", {63'd0, err_credit_ovf}, 64'd1);
    for (int i = 0; i < 118; i++) step(1'b1, $urandom, 1'b0, '0);
    chk("credit_10", {56'd0, credit_count}, 64'd10);
    step(1'b1, 32'hCAFEF00D, 1'b0, UPD);
    chk("upd_xfer_credit", {56'd0, credit_count}, 64'd73);

    // Resend stall in the middle of a stream.
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, $urandom, 1'b1, '0);
      chk("resend_dout", {15'd0, lnk.dout_tx2bft}, 64'd0);
    end
    chk("resend_credit", {56'd0, credit_count}, 64'd68);
    for (int i = 0; i < 6; i++) step(1'b1, $urandom, 1'b0, '0);

    // Reset while a packet is on the output.
    step(1'b1, 32'h0BADF00D, 1'b0, '0);
    do_reset();

    // Randomized traffic against the reference.
    ap_start = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) rnd_pkt = {1'b1, self_leaf, 4'd0, 7'($urandom), 32'($urandom)};
      else if (r < 12) rnd_pkt = {1'b1, 5'($urandom), 4'($urandom), 7'($urandom), 32'($urandom)};
      else rnd_pkt = '0;
      step($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 5, rnd_pkt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
